pp_accum: RTL
=============

PP_ACCUM -- requirements
Module: pp_accum

Interface
REQ-001 SHALL have parameter W_IN, default 10, meaning signed input sample width (the narrowed, saturated sample width).
REQ-002 SHALL have parameter LOG2N_MAX, default 6, meaning the largest supported block length exponent (N = 2^log2n samples).
REQ-003 SHALL have parameter W_OUT, default 16, meaning output width; elaboration SHALL fail unless W_OUT == W_IN + LOG2N_MAX.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in  input  W_IN  signed sample, valid only when strobe_in=1.
REQ-007 strobe_in  input  1  sample-valid qualifier, any duty cycle including back-to-back.
REQ-008 log2n  input  3  block length exponent; values > LOG2N_MAX treated as LOG2N_MAX.
REQ-009 clear  input  1  synchronous abort of the block in progress.
REQ-010 out  output  W_OUT  signed, full-scale-normalised block sum.
REQ-011 strobe_out  output  1  one-cycle pulse, out/clip_count valid.
REQ-012 clip_count  output  LOG2N_MAX+1  count of rail-valued samples in the block.

Function
REQ-013 Each strobe_in sample SHALL be sign-extended and added to an internal accumulator; non-strobe cycles SHALL leave all state unchanged.
REQ-014 log2n SHALL be latched on the first strobe_in of each block (sample counter = 0); changes mid-block SHALL be ignored until the next block.
REQ-015 The block SHALL complete on the N-th strobe_in, N = 2^latched log2n; log2n=0 gives N=1.
REQ-016 On completion, out SHALL be (sum of N samples) shifted left by (LOG2N_MAX - latched log2n), exact with no overflow or rounding.
REQ-017 strobe_out SHALL assert exactly one cycle after the clock edge sampling the completing strobe_in, for one cycle; out and clip_count SHALL update on that same edge and hold until the next completion.
REQ-018 On completion the accumulator, sample counter and clip counter SHALL restart so that a strobe_in on the next cycle is the first sample of the new block (no lost samples).
REQ-019 A sample SHALL count as rail-valued when in equals the most positive (2^(W_IN-1)-1) or most negative (-2^(W_IN-1)) value; clip_count SHALL include the completing sample.
REQ-020 clear=1 SHALL zero accumulator, sample counter and clip counter without asserting strobe_out or changing out/clip_count.
REQ-021 clear=1 together with strobe_in=1 SHALL discard that sample (clear wins).
REQ-022 Sample counter SHALL be LOG2N_MAX bits wide and SHALL never wrap within a block.

Reset
REQ-023 rst_n low SHALL asynchronously force out=0, strobe_out=0, clip_count=0, accumulator=0, counters=0, latched log2n=0.
REQ-024 Reset mid-block SHALL discard the partial block; the first strobe_in after release SHALL start a new block.
REQ-025 Release SHALL be usable on any edge; no strobe_out SHALL occur on the release cycle.

Structure
REQ-026 Shared package pp_pkg SHALL hold default W_IN, LOG2N_MAX, and the derived W_OUT.
REQ-027 Rail detection SHALL be a sub-module pp_rail_detect (combinational, parameter W_IN, outputs is_max, is_min).
REQ-028 Target size 120-400 lines RTL; single always block for sequential state plus rail-detect instance.

Verification
REQ-029 log2n=2, strobe every cycle, in=100,200,-50,7 -> one strobe_out, out=257<<4=4112, clip_count=0.
REQ-030 log2n=6, 64 samples of 511 -> out=32704; 64 samples of -512 -> out=-32768, clip_count=64.
REQ-031 log2n=0, strobe_in every 3rd cycle, in=-3 -> strobe_out each time, 1 cycle later, out=-3<<6=-192.
REQ-032 log2n=2, 2 samples, clear with 3rd strobe_in, then 4 samples of 1 -> single strobe_out, out=64, previous out unchanged until then.
REQ-033 log2n=3, rst_n low after 5 samples, release, 8 samples of 2 -> no strobe_out before 8th post-reset sample; out=16<<3=128.
REQ-034 log2n changed 1->3 mid-block after 1 sample -> that block completes at 2 samples; next block at 8.

Source files
------------

// File: rtl/pp_pkg.sv
// pp_pkg: shared defaults for the pp_accum block-sum accumulator.
//   PP_W_IN       default signed input sample width
//   PP_LOG2N_MAX  default largest block length exponent (N = 2^log2n)
//   PP_W_OUT      derived output width, always PP_W_IN + PP_LOG2N_MAX
//   clamp_log2n   limits a requested exponent to the supported maximum
package pp_pkg;

  localparam int PP_W_IN      = 10;
  localparam int PP_LOG2N_MAX = 6;
  localparam int PP_W_OUT     = PP_W_IN + PP_LOG2N_MAX;

  function automatic logic [2:0] clamp_log2n(input logic [2:0] k,
                                             input logic [2:0] kmax);
    return (k > kmax) ? kmax : k;
  endfunction

endpackage

// File: rtl/pp_rail_detect.sv
// pp_rail_detect: flags a signed sample sitting on either rail.
//   in      signed sample
//   is_max  in equals the most positive value  2^(W_IN-1)-1
//   is_min  in equals the most negative value -2^(W_IN-1)
module pp_rail_detect
  import pp_pkg::*;
#(
  parameter int W_IN = PP_W_IN
) (
  input  logic signed [W_IN-1:0] in,
  output logic                   is_max,
  output logic                   is_min
);

  assign is_max = (in == {1'b0, {(W_IN-1){1'b1}}});
  assign is_min = (in == {1'b1, {(W_IN-1){1'b0}}});

endmodule

// File: rtl/pp_accum.sv
// pp_accum: sums blocks of N = 2^log2n signed samples and reports the sum
// normalised to full scale (shifted left by LOG2N_MAX - log2n), together with
// the number of rail-valued samples in the block.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in           signed sample, qualified by strobe_in
//   strobe_in    sample valid; any duty cycle, back-to-back allowed
//   log2n        block length exponent, latched on the first sample of a block
//   clear        synchronous abort of the block in progress
//   out          signed normalised block sum, held between completions
//   strobe_out   one-cycle pulse when out/clip_count carry a new result
//   clip_count   rail-valued samples counted in the completed block
//
// Handshake: strobe-only, no back-pressure. A sample is consumed on every
// rising edge where strobe_in=1 and clear=0; the consumer must accept the
// result on the single cycle strobe_out=1 (out/clip_count then hold anyway).
module pp_accum
  import pp_pkg::*;
#(
  parameter int W_IN      = PP_W_IN,
  parameter int LOG2N_MAX = PP_LOG2N_MAX,
  parameter int W_OUT     = PP_W_OUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [W_IN-1:0]  in,
  input  logic                    strobe_in,
  input  logic [2:0]              log2n,
  input  logic                    clear,
  output logic signed [W_OUT-1:0] out,
  output logic                    strobe_out,
  output logic [LOG2N_MAX:0]      clip_count
);

  // The normalised sum only fits exactly if the output carries LOG2N_MAX
  // bits of headroom above the sample width.
  if (W_OUT != W_IN + LOG2N_MAX) begin : g_bad_w_out
    $fatal(1, "pp_accum: W_OUT must equal W_IN + LOG2N_MAX");
  end
  // log2n is a 3-bit port, so exponents above 7 are unreachable.
  if (LOG2N_MAX < 1 || LOG2N_MAX > 7) begin : g_bad_log2n_max
    $fatal(1, "pp_accum: LOG2N_MAX must be in 1..7");
  end

  localparam int         CW   = LOG2N_MAX;
  localparam int         NW   = LOG2N_MAX + 1;
  localparam logic [2:0] KMAX = 3'(LOG2N_MAX);

  logic signed [W_OUT-1:0] acc;
  logic [CW-1:0]           cnt;
  logic [NW-1:0]           clip_cnt;
  logic [2:0]              lat_log2n;

  logic                    is_max;
  logic                    is_min;
  logic [2:0]              eff_log2n;
  logic [2:0]              shamt;
  logic [NW-1:0]           n_last;
  logic                    last;
  logic signed [W_OUT-1:0] ext;
  logic signed [W_OUT-1:0] sum_next;
  logic signed [W_OUT-1:0] out_next;
  logic [NW-1:0]           clip_next;

  pp_rail_detect #(
    .W_IN (W_IN)
  ) u_rail (
    .in     (in),
    .is_max (is_max),
    .is_min (is_min)
  );

  always_comb begin
    // The first sample of a block uses the live exponent; later samples use
    // the copy latched with that first sample.
    eff_log2n = (cnt == '0) ? clamp_log2n(log2n, KMAX) : lat_log2n;
    shamt     = KMAX - eff_log2n;
    n_last    = (NW'(1) << eff_log2n) - NW'(1);
    // cnt holds samples already taken, so it peaks at N-1 and never wraps.
    last      = ({1'b0, cnt} == n_last);
    ext       = {{LOG2N_MAX{in[W_IN-1]}}, in};
    sum_next  = acc + ext;
    out_next  = sum_next << shamt;
    clip_next = clip_cnt + NW'(is_max | is_min);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      clip_cnt   <= '0;
      lat_log2n  <= '0;
      out        <= '0;
      clip_count <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      if (clear) begin
        // Abort wins over a coincident sample; the last result stays visible.
        acc      <= '0;
        cnt      <= '0;
        clip_cnt <= '0;
      end else if (strobe_in) begin
        if (cnt == '0) begin
          lat_log2n <= eff_log2n;
        end
        if (last) begin
          out        <= out_next;
          clip_count <= clip_next;
          strobe_out <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          clip_cnt   <= '0;
        end else begin
          acc      <= sum_next;
          cnt      <= cnt + CW'(1);
          clip_cnt <= clip_next;
        end
      end
    end
  end

endmodule
